tl_axi_master: RTL

- PCIe completer-side transaction-layer bridge: the inbound counterpart to the requester-side AXI slave packer.
- Pops received MemWr/MemRd TLP headers and write payload from the Rx P and NP FIFOs, and drives an AXI4 master into local memory.
- Returns read data as CplD TLPs (3DW header plus 256-bit data) into the Tx Cpl FIFOs.
- Handles one request at a time.

---
 rtl/tl_axi_master_if.sv | 104 ++++++++++
 rtl/tl_axi_master.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/tl_axi_master_if.sv
// TLP header layouts and AXI4 channel interfaces shared by the completer bridge.
// In every channel interface the master modport drives valid/payload and the slave modport drives ready.
package PCIE_PKG;

    // Header DWs in wire order. Address bytes are held little-endian within each field.
    typedef struct packed {
        logic [2:0]  fmt;
        logic [4:0]  tlp_type;
        logic        tg_h;
        logic [2:0]  tc;
        logic        tg_m;
        logic        attr_h;
        logic        ln;
        logic        th;
        logic        td;
        logic        ep;
        logic [1:0]  attr_l;
        logic [1:0]  at;
        logic [1:0]  length_h;
        logic [7:0]  length_l;
        logic [15:0] requester_id;
        logic [7:0]  tag;
        logic [3:0]  last_be;
        logic [3:0]  first_be;
        logic [31:0] addr_h;
        logic [23:0] addr_m;
        logic [5:0]  addr_l;
        logic [1:0]  rsvd;
    } tlp_memory_req_hdr_t;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [4:0]  tlp_type;
        logic        tg_h;
        logic [2:0]  tc;
        logic        tg_m;
        logic        attr_h;
        logic        ln;
        logic        th;
        logic        td;
        logic        ep;
        logic [1:0]  attr_l;
        logic [1:0]  at;
        logic [1:0]  length_h;
        logic [7:0]  length_l;
        logic [15:0] completer_id;
        logic [2:0]  status;
        logic        bcm;
        logic [11:0] byte_count;
        logic [15:0] requester_id;
        logic [7:0]  tag;
        logic        rsvd;
        logic [6:0]  lower_addr;
    } tlp_cpl_hdr_t;

endpackage

interface AXI4_A_IF #(parameter int ID_WIDTH = 4, parameter int ADDR_WIDTH = 64);
  logic                  avalid;
  logic                  aready;
  logic [ID_WIDTH-1:0]   aid;
  logic [ADDR_WIDTH-1:0] aaddr;
  logic [7:0]            alen;
  logic [2:0]            asize;
  logic [1:0]            aburst;
  logic [3:0]            acache;
  logic [2:0]            aprot;
  logic [3:0]            aqos;
  logic [3:0]            aregion;
  modport master (output avalid, aid, aaddr, alen, asize, aburst, acache, aprot, aqos, aregion,
                  input aready);
  modport slave  (input avalid, aid, aaddr, alen, asize, aburst, acache, aprot, aqos, aregion,
                  output aready);
endinterface

interface AXI4_W_IF #(parameter int DATA_WIDTH = 256);
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  modport master (output wvalid, wdata, wstrb, wlast, input wready);
  modport slave  (input wvalid, wdata, wstrb, wlast, output wready);
endinterface

interface AXI4_R_IF #(parameter int ID_WIDTH = 4, parameter int DATA_WIDTH = 256);
  logic                  rvalid;
  logic                  rready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  modport master (output rvalid, rid, rdata, rresp, rlast, input rready);
  modport slave  (input rvalid, rid, rdata, rresp, rlast, output rready);
endinterface

interface AXI4_B_IF #(parameter int ID_WIDTH = 4);
  logic                bvalid;
  logic                bready;
  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;
  modport master (output bvalid, bid, bresp, input bready);
  modport slave  (input bvalid, bid, bresp, output bready);
endinterface

// File: rtl/tl_axi_master.sv
// Completer-side bridge: serves Rx MemWr/MemRd TLPs one at a time over an AXI4 master
// and returns read data as 3DW CplD TLPs chunked at the max payload size.
module tl_axi_master
  import PCIE_PKG::*;
#(
  parameter int AXI_ID_WIDTH      = 4,
  parameter int AXI_ADDR_WIDTH    = 64,
  parameter int MAX_PAYLOAD_SIZE  = 128,
  parameter int MAX_READ_REQ_SIZE = 512
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   config_bdf_i,
  AXI4_A_IF.master      aw_if,
  AXI4_A_IF.master      ar_if,
  AXI4_W_IF.master      w_if,
  AXI4_R_IF.slave       r_if,
  AXI4_B_IF.slave       b_if,
  input  logic          p_hdr_empty_i,
  input  logic [127:0]  p_hdr_rdata_i,
  output logic          p_hdr_rden_o,
  input  logic          p_data_empty_i,
  input  logic [255:0]  p_data_rdata_i,
  output logic          p_data_rden_o,
  input  logic          np_hdr_empty_i,
  input  logic [127:0]  np_hdr_rdata_i,
  output logic          np_hdr_rden_o,
  input  logic          cpl_hdr_full_i,
  output logic [95:0]   cpl_hdr_wdata_o,
  output logic          cpl_hdr_wren_o,
  input  logic          cpl_data_full_i,
  output logic [255:0]  cpl_data_wdata_o,
  output logic          cpl_data_wren_o
);

  localparam int CHUNK_BEATS = MAX_PAYLOAD_SIZE / 32;
  localparam int CHUNK_W     = (CHUNK_BEATS > 1) ? $clog2(CHUNK_BEATS) : 1;
  localparam int RD_CNT_W    = $clog2(MAX_READ_REQ_SIZE / 32) + 1;

  typedef enum logic [2:0] {IDLE, WR_AW, WR_W, WR_B, RD_AR, RD_R} state_t;

  state_t               state_reg, state_next;
  logic [10:0]          len_reg;
  logic [7:0]           beats_reg;
  logic [9:0]           tag_reg;
  logic [15:0]          req_id_reg;
  logic [63:0]          addr_reg;
  logic [7:0]           wr_cnt_reg;
  logic [RD_CNT_W-1:0]  rd_cnt_reg;
  logic [CHUNK_W-1:0]   chunk_reg;
  logic [12:0]          sent_reg;

  tlp_memory_req_hdr_t  req_hdr;
  tlp_cpl_hdr_t         cpl_hdr;
  logic [9:0]           len_dw;
  logic [10:0]          len_full;
  logic [63:0]          req_addr;
  logic [7:0]           alen;
  logic [12:0]          remaining;
  logic [12:0]          chunk_bytes;
  logic                 aw_valid, ar_valid, w_valid, w_last, r_ready, b_ready;
  logic                 r_fire;
  logic                 unused_ok;

  function automatic logic [31:0] brev32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [23:0] brev24(input logic [23:0] x);
    return {x[7:0], x[15:8], x[23:16]};
  endfunction

  // P has priority, so the header being decoded is the one IDLE will pop.
  assign req_hdr  = p_hdr_empty_i ? np_hdr_rdata_i : p_hdr_rdata_i;
  assign len_dw   = {req_hdr.length_h, req_hdr.length_l};
  assign len_full = (len_dw == 10'd0) ? 11'd1024 : {1'b0, len_dw};
  assign req_addr = {brev32(req_hdr.addr_h), brev24(req_hdr.addr_m), req_hdr.addr_l, 2'b00};
  assign alen     = beats_reg - 8'd1;

  assign aw_if.avalid  = aw_valid;
  assign aw_if.aid     = AXI_ID_WIDTH'(tag_reg[9:6]);
  assign aw_if.aaddr   = AXI_ADDR_WIDTH'(addr_reg);
  assign aw_if.alen    = alen;
  assign aw_if.asize   = 3'd5;
  assign aw_if.aburst  = 2'b01;
  assign aw_if.acache  = 4'd0;
  assign aw_if.aprot   = 3'd0;
  assign aw_if.aqos    = 4'd0;
  assign aw_if.aregion = 4'd0;

  assign ar_if.avalid  = ar_valid;
  assign ar_if.aid     = AXI_ID_WIDTH'(tag_reg[9:6]);
  assign ar_if.aaddr   = AXI_ADDR_WIDTH'(addr_reg);
  assign ar_if.alen    = alen;
  assign ar_if.asize   = 3'd5;
  assign ar_if.aburst  = 2'b01;
  assign ar_if.acache  = 4'd0;
  assign ar_if.aprot   = 3'd0;
  assign ar_if.aqos    = 4'd0;
  assign ar_if.aregion = 4'd0;

  assign w_if.wvalid = w_valid;
  assign w_if.wdata  = p_data_rdata_i;
  assign w_if.wstrb  = '1;
  assign w_if.wlast  = w_last;
  assign r_if.rready = r_ready;
  assign b_if.bready = b_ready;

  assign r_fire = r_ready & r_if.rvalid;

  always_comb begin
    state_next      = state_reg;
    p_hdr_rden_o    = 1'b0;
    np_hdr_rden_o   = 1'b0;
    p_data_rden_o   = 1'b0;
    cpl_hdr_wren_o  = 1'b0;
    cpl_data_wren_o = 1'b0;
    aw_valid        = 1'b0;
    ar_valid        = 1'b0;
    w_valid         = 1'b0;
    w_last          = 1'b0;
    r_ready         = 1'b0;
    b_ready         = 1'b0;
    case (state_reg)
      IDLE: begin
        // Pops are held off while reset is asserted so no header is lost.
        if (rst_n && !p_hdr_empty_i) begin
          p_hdr_rden_o = 1'b1;
          state_next   = WR_AW;
        end else if (rst_n && !np_hdr_empty_i) begin
          np_hdr_rden_o = 1'b1;
          state_next    = RD_AR;
        end
      end
      WR_AW: begin
        aw_valid = 1'b1;
        if (aw_if.aready) state_next = WR_W;
      end
      WR_W: begin
        w_valid       = !p_data_empty_i;
        w_last        = (wr_cnt_reg == alen);
        p_data_rden_o = w_valid & w_if.wready;
        if (p_data_rden_o && w_last) state_next = WR_B;
      end
      WR_B: begin
        b_ready = 1'b1;
        if (b_if.bvalid) state_next = IDLE;
      end
      RD_AR: begin
        ar_valid = 1'b1;
        if (ar_if.aready) state_next = RD_R;
      end
      RD_R: begin
        r_ready         = !cpl_data_full_i & ((chunk_reg != '0) | !cpl_hdr_full_i);
        cpl_data_wren_o = r_fire;
        cpl_hdr_wren_o  = r_fire & (chunk_reg == '0);
        if (r_fire && (r_if.rlast || (8'(rd_cnt_reg) + 8'd1 == beats_reg))) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign remaining   = {len_reg, 2'b00} - sent_reg;
  assign chunk_bytes = (remaining > 13'(MAX_PAYLOAD_SIZE)) ? 13'(MAX_PAYLOAD_SIZE) : remaining;

  always_comb begin
    cpl_hdr              = '0;
    cpl_hdr.fmt          = 3'b010;
    cpl_hdr.tlp_type     = 5'b01010;
    cpl_hdr.tg_h         = tag_reg[9];
    cpl_hdr.tg_m         = tag_reg[8];
    {cpl_hdr.length_h, cpl_hdr.length_l} = chunk_bytes[11:2];
    cpl_hdr.completer_id = config_bdf_i;
    cpl_hdr.byte_count   = remaining[11:0];
    cpl_hdr.requester_id = req_id_reg;
    cpl_hdr.tag          = tag_reg[7:0];
    cpl_hdr.lower_addr   = addr_reg[6:0] + sent_reg[6:0];
  end

  assign cpl_hdr_wdata_o  = cpl_hdr;
  assign cpl_data_wdata_o = r_if.rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      len_reg    <= '0;
      beats_reg  <= '0;
      tag_reg    <= '0;
      req_id_reg <= '0;
      addr_reg   <= '0;
      wr_cnt_reg <= '0;
      rd_cnt_reg <= '0;
      chunk_reg  <= '0;
      sent_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (p_hdr_rden_o || np_hdr_rden_o) begin
        len_reg    <= len_full;
        beats_reg  <= len_full[10:3];
        tag_reg    <= {req_hdr.tg_h, req_hdr.tg_m, req_hdr.tag};
        req_id_reg <= req_hdr.requester_id;
        addr_reg   <= req_addr;
      end
      if (state_reg == WR_AW) wr_cnt_reg <= '0;
      else if (p_data_rden_o) wr_cnt_reg <= wr_cnt_reg + 8'd1;
      if (state_reg == RD_AR) begin
        rd_cnt_reg <= '0;
        chunk_reg  <= '0;
        sent_reg   <= '0;
      end else if (r_fire) begin
        rd_cnt_reg <= rd_cnt_reg + RD_CNT_W'(1);
        chunk_reg  <= (chunk_reg == CHUNK_W'(CHUNK_BEATS - 1)) ? '0 : chunk_reg + CHUNK_W'(1);
        sent_reg   <= sent_reg + 13'd32;
      end
    end
  end

  assign unused_ok = ^{r_if.rid, r_if.rresp, b_if.bid, b_if.bresp, req_hdr.fmt, req_hdr.tlp_type,
                       req_hdr.tc, req_hdr.attr_h, req_hdr.ln, req_hdr.th, req_hdr.td, req_hdr.ep,
                       req_hdr.attr_l, req_hdr.at, req_hdr.last_be, req_hdr.first_be, req_hdr.rsvd,
                       chunk_bytes[12], chunk_bytes[1:0]};

endmodule
